countdown_ctrl: RTL and testbench

Sequencing controller for the mm:ss countdown timer. It owns the 1 Hz timebase prescaler, the RUN/PAUSE/EXPIRED state machine and the chained BCD digit cascade (seconds units mod-10, seconds tens mod-6, minutes units mod-10, minutes tens mod-6). It turns debounced single-cycle button pulses into digit enables and borrows, and raises a done/alarm indication when the count reaches 00:00. It sits between the button debouncers and the seven-segment display multiplexer.

---
 rtl/countdown_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_countdown_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: mm:ss countdown sequencer (1 Hz prescaler, IDLE/RUN/PAUSE/EXPIRED FSM, BCD borrow cascade).
// Optional build macro COUNTDOWN_AUTORELOAD_EN: reload the preset on reaching 00:00 instead of expiring.
module countdown_ctrl #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic [2:0] preset_m10,
   input  logic [3:0] preset_m1,
   input  logic [2:0] preset_s10,
   input  logic [3:0] preset_s1,
   output logic [2:0] m10,
   output logic [3:0] m1,
   output logic [2:0] s10,
   output logic [3:0] s1,
   output logic       running,
   output logic       done,
   output logic       alarm,
   output logic       tick
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   state_t        state_r;
   logic [PW-1:0] pre_r;
   logic [2:0]    m10_r;
   logic [3:0]    m1_r;
   logic [2:0]    s10_r;
   logic [3:0]    s1_r;
   logic          running_r;
   logic          done_r;
   logic          alarm_r;

   logic [2:0]    dec_m10_s;
   logic [3:0]    dec_m1_s;
   logic [2:0]    dec_s10_s;
   logic [3:0]    dec_s1_s;
   logic          borrow_s10_s;
   logic          borrow_m1_s;
   logic          borrow_m10_s;
   logic          dec_zero_s;
   logic          digits_zero_s;
   logic [2:0]    cl_m10_s;
   logic [3:0]    cl_m1_s;
   logic [2:0]    cl_s10_s;
   logic [3:0]    cl_s1_s;
   logic          preset_zero_s;
   logic          tick_s;

   function automatic logic [2:0] clamp_tens(input logic [2:0] v);
      return (v > 3'd5) ? 3'd5 : v;
   endfunction

   function automatic logic [3:0] clamp_units(input logic [3:0] v);
      return (v > 4'd9) ? 4'd9 : v;
   endfunction

   // Clamped preset values and zero detection for load/start decisions.
   always_comb begin
      cl_m10_s      = clamp_tens(preset_m10);
      cl_m1_s       = clamp_units(preset_m1);
      cl_s10_s      = clamp_tens(preset_s10);
      cl_s1_s       = clamp_units(preset_s1);
      preset_zero_s = (cl_m10_s == 3'd0) && (cl_m1_s == 4'd0) &&
                      (cl_s10_s == 3'd0) && (cl_s1_s == 4'd0);
      digits_zero_s = (m10_r == 3'd0) && (m1_r == 4'd0) &&
                      (s10_r == 3'd0) && (s1_r == 4'd0);
   end

   // One-step decrement of the digit chain; each stage borrows from the next when it wraps.
   always_comb begin
      dec_s1_s     = s1_r;
      dec_s10_s    = s10_r;
      dec_m1_s     = m1_r;
      dec_m10_s    = m10_r;
      borrow_s10_s = 1'b0;
      borrow_m1_s  = 1'b0;
      borrow_m10_s = 1'b0;
      if (s1_r == 4'd0) begin
         dec_s1_s     = 4'd9;
         borrow_s10_s = 1'b1;
      end else begin
         dec_s1_s     = s1_r - 4'd1;
      end
      if (borrow_s10_s) begin
         if (s10_r == 3'd0) begin
            dec_s10_s   = 3'd5;
            borrow_m1_s = 1'b1;
         end else begin
            dec_s10_s   = s10_r - 3'd1;
         end
      end else begin
         dec_s10_s = s10_r;
      end
      if (borrow_m1_s) begin
         if (m1_r == 4'd0) begin
            dec_m1_s     = 4'd9;
            borrow_m10_s = 1'b1;
         end else begin
            dec_m1_s     = m1_r - 4'd1;
         end
      end else begin
         dec_m1_s = m1_r;
      end
      if (borrow_m10_s) begin
         dec_m10_s = (m10_r == 3'd0) ? 3'd0 : (m10_r - 3'd1);
      end else begin
         dec_m10_s = m10_r;
      end
      dec_zero_s = (dec_m10_s == 3'd0) && (dec_m1_s == 4'd0) &&
                   (dec_s10_s == 3'd0) && (dec_s1_s == 4'd0);
   end

   // The tick is suppressed by a same-cycle stop or clear so the prescaler can hold at its last count.
   always_comb begin
      tick_s = (state_r == ST_RUN) && (pre_r == PRE_MAX) && !stop && !clear;
   end

   // Controller FSM: prescaler, digits and all registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         pre_r     <= '0;
         m10_r     <= 3'd0;
         m1_r      <= 4'd0;
         s10_r     <= 3'd0;
         s1_r      <= 4'd0;
         running_r <= 1'b0;
         done_r    <= 1'b0;
         alarm_r   <= 1'b0;
      end else begin
         alarm_r <= 1'b0;
         if (clear) begin
            m10_r     <= cl_m10_s;
            m1_r      <= cl_m1_s;
            s10_r     <= cl_s10_s;
            s1_r      <= cl_s1_s;
            pre_r     <= '0;
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
            done_r    <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (start && !stop && !digits_zero_s) begin
                     state_r   <= ST_RUN;
                     pre_r     <= '0;
                     running_r <= 1'b1;
                  end else begin
                     state_r   <= ST_IDLE;
                  end
               end
               ST_RUN: begin
                  if (stop) begin
                     state_r   <= ST_PAUSE;
                     running_r <= 1'b0;
                  end else if (tick_s) begin
                     pre_r <= '0;
                     m10_r <= dec_m10_s;
                     m1_r  <= dec_m1_s;
                     s10_r <= dec_s10_s;
                     s1_r  <= dec_s1_s;
                     if (dec_zero_s) begin
                        alarm_r <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                        m10_r <= cl_m10_s;
                        m1_r  <= cl_m1_s;
                        s10_r <= cl_s10_s;
                        s1_r  <= cl_s1_s;
                        if (preset_zero_s) begin
                           state_r   <= ST_IDLE;
                           running_r <= 1'b0;
                        end else begin
                           state_r   <= ST_RUN;
                        end
`else
                        state_r   <= ST_EXPIRED;
                        running_r <= 1'b0;
                        done_r    <= 1'b1;
`endif
                     end else begin
                        state_r <= ST_RUN;
                     end
                  end else begin
                     pre_r <= pre_r + PW'(1);
                  end
               end
               ST_PAUSE: begin
                  if (start && !stop) begin
                     state_r   <= ST_RUN;
                     running_r <= 1'b1;
                  end else begin
                     state_r   <= ST_PAUSE;
                  end
               end
               ST_EXPIRED: begin
                  state_r <= ST_EXPIRED;
                  done_r  <= 1'b1;
               end
               default: begin
                  state_r   <= ST_IDLE;
                  pre_r     <= '0;
                  running_r <= 1'b0;
                  done_r    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign m10     = m10_r;
   assign m1      = m1_r;
   assign s10     = s10_r;
   assign s1      = s1_r;
   assign running = running_r;
   assign done    = done_r;
   assign alarm   = alarm_r;
   assign tick    = tick_s;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed, table-driven bench for countdown_ctrl with TICK_DIV = 4.
module tb_countdown_ctrl;
   localparam int unsigned TD = 4;
`ifdef COUNTDOWN_AUTORELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, start, stop, clear;
   logic [2:0] preset_m10, preset_s10, m10, s10;
   logic [3:0] preset_m1, preset_s1, m1, s1;
   logic       running, done, alarm, tick;
   logic       tick_seen;

   always #5 clk = ~clk;

   countdown_ctrl #(.TICK_DIV(TD)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .preset_m10(preset_m10), .preset_m1(preset_m1),
      .preset_s10(preset_s10), .preset_s1(preset_s1),
      .m10(m10), .m1(m1), .s10(s10), .s1(s1),
      .running(running), .done(done), .alarm(alarm), .tick(tick)
   );

   typedef struct {
      logic        st, sp, cl;
      logic [13:0] pre;
      logic [13:0] dig;
      logic        run, dn, al, tk;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [13:0] bcd(input int a, input int b, input int c, input int d);
      return {3'(a), 4'(b), 3'(c), 4'(d)};
   endfunction

   function automatic vec_t mk(input logic st, input logic sp, input logic cl,
                               input logic [13:0] pre, input logic [13:0] dig,
                               input logic run, input logic dn, input logic al, input logic tk);
      vec_t v;
      v.st = st; v.sp = sp; v.cl = cl; v.pre = pre; v.dig = dig;
      v.run = run; v.dn = dn; v.al = al; v.tk = tk;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs; tick is sampled mid-cycle, outputs are valid #1 after the edge.
   task automatic cyc(input logic s, input logic p, input logic c, input logic [13:0] pr);
      start = s; stop = p; clear = c;
      {preset_m10, preset_m1, preset_s10, preset_s1} = pr;
      @(negedge clk);
      tick_seen = tick;
      @(posedge clk);
      #1;
      start = 1'b0; stop = 1'b0; clear = 1'b0;
   endtask

   task automatic chk_out(input string name, input logic [13:0] dig,
                          input logic run, input logic dn, input logic al);
      chk({name, " digits"},  32'({m10, m1, s10, s1}), 32'(dig));
      chk({name, " running"}, 32'(running), 32'(run));
      chk({name, " done"},    32'(done),    32'(dn));
      chk({name, " alarm"},   32'(alarm),   32'(al));
   endtask

   initial begin
      logic [13:0] z;
      z = 14'd0;
      reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
      {preset_m10, preset_m1, preset_s10, preset_s1} = z;
      tick_seen = 1'b0;

      // 00:03 countdown to expiry, then start/stop must be ignored
      vecs.push_back(mk(0, 0, 1, bcd(0,0,0,3), bcd(0,0,0,3), 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, z,            bcd(0,0,0,3), 1, 0, 0, 0));
      for (int k = 3; k >= 1; k--) begin
         for (int j = 0; j < 3; j++)
            vecs.push_back(mk(0, 0, 0, z, bcd(0,0,0,k), 1, 0, 0, 0));
         if (k > 1)
            vecs.push_back(mk(0, 0, 0, z, bcd(0,0,0,k-1), 1, 0, 0, 1));
         else
            vecs.push_back(mk(0, 0, 0, bcd(0,0,0,3), AR ? bcd(0,0,0,3) : z, AR, !AR, 1, 1));
      end
      vecs.push_back(mk(0, 0, 0, z, AR ? bcd(0,0,0,3) : z, AR, !AR, 0, 0));
      vecs.push_back(mk(1, 0, 0, z, AR ? bcd(0,0,0,3) : z, AR, !AR, 0, 0));
      vecs.push_back(mk(0, 1, 0, z, AR ? bcd(0,0,0,3) : z, 0,  !AR, 0, 0));
      // 01:00 -> 00:59 after one tick; a mid-run clear to 10:00 then -> 09:59
      vecs.push_back(mk(0, 0, 1, bcd(0,1,0,0), bcd(0,1,0,0), 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, z,            bcd(0,1,0,0), 1, 0, 0, 0));
      for (int j = 0; j < 3; j++)
         vecs.push_back(mk(0, 0, 0, z, bcd(0,1,0,0), 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, z,            bcd(0,0,5,9), 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, bcd(1,0,0,0), bcd(1,0,0,0), 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, z,            bcd(1,0,0,0), 1, 0, 0, 0));
      for (int j = 0; j < 3; j++)
         vecs.push_back(mk(0, 0, 0, z, bcd(1,0,0,0), 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, z,            bcd(0,9,5,9), 1, 0, 0, 1));
      // clear+start together, preset clamping, start with 00:00 loaded
      vecs.push_back(mk(1, 0, 1, bcd(0,0,7,12),  bcd(0,0,5,9), 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, bcd(6,15,7,12), bcd(5,9,5,9), 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, z,              z,            0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, z,              z,            0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, z,              z,            0, 0, 0, 0));

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk_out("reset", z, 0, 0, 0);
      chk("reset tick", 32'(tick), 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         cyc(vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].pre);
         chk($sformatf("v%0d tick", i), 32'(tick_seen), 32'(vecs[i].tk));
         chk_out($sformatf("v%0d", i), vecs[i].dig, vecs[i].run, vecs[i].dn, vecs[i].al);
      end

      // Pause with prescaler at 2: digits frozen, next tick two cycles after resume
      cyc(0, 0, 1, bcd(0,0,0,5));
      cyc(1, 0, 0, z);
      cyc(0, 0, 0, z);
      cyc(0, 0, 0, z);
      cyc(0, 1, 0, z);
      chk_out("pause", bcd(0,0,0,5), 0, 0, 0);
      for (int j = 0; j < 20; j++) begin
         cyc(0, 0, 0, z);
         chk("paused tick", 32'(tick_seen), 32'd0);
      end
      chk_out("paused", bcd(0,0,0,5), 0, 0, 0);
      cyc(1, 0, 0, z);
      chk_out("resume", bcd(0,0,0,5), 1, 0, 0);
      cyc(0, 0, 0, z);
      chk("resume c1 tick", 32'(tick_seen), 32'd0);
      cyc(0, 0, 0, z);
      chk("resume c2 tick", 32'(tick_seen), 32'd1);
      chk_out("resume tick", bcd(0,0,0,4), 1, 0, 0);

      // stop in the tick cycle: no decrement, and the tick fires on the first cycle after resume
      for (int j = 0; j < 3; j++) cyc(0, 0, 0, z);
      cyc(0, 1, 0, z);
      chk("stop+tick tick", 32'(tick_seen), 32'd0);
      chk_out("stop+tick", bcd(0,0,0,4), 0, 0, 0);
      cyc(1, 0, 0, z);
      cyc(0, 0, 0, z);
      chk("held tick", 32'(tick_seen), 32'd1);
      chk_out("held tick", bcd(0,0,0,3), 1, 0, 0);

      // reset mid-run clears everything without an alarm
      reset = 1'b1;
      cyc(0, 0, 0, z);
      reset = 1'b0;
      chk_out("mid reset", z, 0, 0, 0);

`ifdef COUNTDOWN_AUTORELOAD_EN
      cyc(0, 0, 1, bcd(0,0,0,2));
      cyc(1, 0, 0, bcd(0,0,0,2));
      for (int k = 0; k < 16; k++) begin
         cyc(0, 0, 0, bcd(0,0,0,2));
         chk($sformatf("reload k%0d alarm", k), 32'(alarm), 32'(k == 7 || k == 15));
         chk($sformatf("reload k%0d done", k), 32'(done), 32'd0);
         if (k == 7 || k == 15)
            chk($sformatf("reload k%0d digits", k), 32'({m10, m1, s10, s1}), 32'(bcd(0,0,0,2)));
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
